multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: Opcode  in  6  instruction opcode from instruction register, sampled in DECODE.
REQ-004 SHALL have ports: Zero  in  1  ALU zero flag, used in BRANCH.
REQ-005 SHALL have ports: MemReady  in  1  memory completes the current access this cycle.
REQ-006 SHALL have ports: MemReq  out  1  memory access request.
REQ-007 SHALL have ports: IorD  out  1  address source; 0 = PC, 1 = ALUOut.
REQ-008 SHALL have ports: MemWrite  out  1  write strobe, valid with MemReq.
REQ-009 SHALL have ports: IRWrite  out  1  instruction register load.
REQ-010 SHALL have ports: PCWrite  out  1  program counter load.
REQ-011 SHALL have ports: RegWrite, RegDst, MemtoReg  out  1 each  register file write, destination select (1 = rd), write-data select (1 = memory).
REQ-012 SHALL have ports: ALUSrcA  out  1 and ALUSrcB  out  2  ALU operand selects (A: 0 = PC, 1 = rs; B: 00 = rt, 01 = 4, 10 = immediate, 11 = immediate<<2).
REQ-013 SHALL have ports: ALUop  out  2  to ALU control unit; 00 = add, 01 = subtract, 10 = decode Function field.
REQ-014 SHALL have ports: PCSrc  out  2  next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-015 SHALL have ports: Fault  out  1  one-cycle pulse on unsupported opcode.
REQ-016 SHALL have ports: State  out  4  current state code, for debug.

Function
REQ-017 SHALL implement Moore FSM with codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 go to FETCH next cycle with all strobes 0.
REQ-018 SHALL hold FETCH: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSrc=00; IRWrite=PCWrite=MemReady (same cycle); advance to DECODE only when MemReady=1, else stay.
REQ-019 SHALL hold DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00; next state by Opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP, other -> FETCH with Fault=1 in the DECODE cycle.
REQ-020 SHALL hold MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=00; -> MEMRD if latched opcode is 100011, else MEMWR.
REQ-021 SHALL hold MEMRD: MemReq=1, IorD=1; stay until MemReady=1, then -> MEMWB.
REQ-022 SHALL hold MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; -> FETCH.
REQ-023 SHALL hold MEMWR: MemReq=1, IorD=1, MemWrite=1; stay until MemReady=1, then -> FETCH.
REQ-024 SHALL hold EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10; -> ALUWB; ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; -> FETCH.
REQ-025 SHALL hold BRANCH: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSrc=01, PCWrite=Zero; -> FETCH.
REQ-026 SHALL hold ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUop=00; -> ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; -> FETCH.
REQ-027 SHALL hold JUMP: PCSrc=10, PCWrite=1; -> FETCH.
REQ-028 SHALL latch Opcode into an internal register in DECODE; MEMADR uses the latched value.
REQ-029 SHALL drive every output not listed for a state to 0; MemWrite and RegWrite SHALL never be 1 simultaneously.
REQ-030 SHALL give latencies with MemReady tied high: R-type/addi/beq(any Zero)/j complete in 4/4/3/3 cycles, lw 5, sw 4.

Reset
REQ-031 SHALL on rst_n=0 force state to FETCH immediately, asynchronously, including mid-access in MEMRD/MEMWR, and clear latched opcode to 0.
REQ-032 SHALL while rst_n=0 drive all outputs 0 except State=0; FETCH outputs start in the first cycle after release.

Verification
REQ-033 SHALL cover: reset release, MemReady=1, Opcode=000000 -> states 0,1,6,7,0; ALUop=10 in EXEC; RegWrite=1, RegDst=1 in ALUWB only.
REQ-034 SHALL cover: lw (100011) with MemReady low 3 cycles in MEMRD -> MEMRD held 4 cycles, MemReq=1, IorD=1 throughout; one RegWrite pulse with MemtoReg=1.
REQ-035 SHALL cover: beq with Zero=1 then Zero=0 -> PCWrite=1, PCSrc=01, ALUop=01 in BRANCH for first; PCWrite=0 for second.
REQ-036 SHALL cover: Opcode=111111 -> Fault=1 for exactly the DECODE cycle; next state FETCH; no RegWrite/MemWrite.
REQ-037 SHALL cover: rst_n low mid-MEMWR with MemReady=0 -> State=0 and MemWrite=0 before next clk edge; no write completes.
REQ-038 SHALL cover: FETCH with MemReady=0 for 2 cycles -> IRWrite=PCWrite=0 while stalled, both 1 in the MemReady=1 cycle, then DECODE.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control-path bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_control_if;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;

    logic       MemReq;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUop;
    logic [1:0] PCSrc;
    logic       Fault;
    logic [3:0] State;

    modport master (
        input  Opcode, Zero, MemReady,
        output MemReq, IorD, MemWrite, IRWrite, PCWrite,
               RegWrite, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ALUop, PCSrc, Fault, State
    );

    modport slave (
        output Opcode, Zero, MemReady,
        input  MemReq, IorD, MemWrite, IRWrite, PCWrite,
               RegWrite, RegDst, MemtoReg,
               ALUSrcA, ALUSrcB, ALUop, PCSrc, Fault, State
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath with a
// handshaked memory (MemReady) and a fault pulse for unknown opcodes.
module multicycle_control (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_e     state_q, state_d;
    logic [5:0] opcode_q, opcode_d;

    function automatic logic opcode_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: opcode_supported = 1'b1;
            default:                                      opcode_supported = 1'b0;
        endcase
    endfunction

    // Reset pulls the machine back to FETCH at once, even mid memory access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            opcode_q <= 6'd0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            FETCH: begin
                if (bus.MemReady) state_d = DECODE;
            end
            DECODE: begin
                opcode_d = bus.Opcode;
                case (bus.Opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            // The live Opcode may already have moved on; use the DECODE copy.
            MEMADR: state_d = (opcode_q == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                if (bus.MemReady) state_d = MEMWB;
            end
            MEMWB:  state_d = FETCH;
            MEMWR: begin
                if (bus.MemReady) state_d = FETCH;
            end
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            ADDIEX: state_d = ADDIWB;
            ADDIWB: state_d = FETCH;
            JUMP:   state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Strobes are held low for the whole time reset is asserted.
    always_comb begin
        bus.MemReq   = 1'b0;
        bus.IorD     = 1'b0;
        bus.MemWrite = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.RegWrite = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.ALUop    = 2'b00;
        bus.PCSrc    = 2'b00;
        bus.Fault    = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    bus.MemReq  = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = bus.MemReady;
                    bus.PCWrite = bus.MemReady;
                end
                DECODE: begin
                    bus.ALUSrcB = 2'b11;
                    bus.Fault   = ~opcode_supported(bus.Opcode);
                end
                MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                MEMRD: begin
                    bus.MemReq = 1'b1;
                    bus.IorD   = 1'b1;
                end
                MEMWB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = 1'b1;
                end
                MEMWR: begin
                    bus.MemReq   = 1'b1;
                    bus.IorD     = 1'b1;
                    bus.MemWrite = 1'b1;
                end
                EXEC: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUop   = 2'b10;
                end
                ALUWB: begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 1'b1;
                end
                BRANCH: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUop   = 2'b01;
                    bus.PCSrc   = 2'b01;
                    bus.PCWrite = bus.Zero;
                end
                ADDIEX: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                ADDIWB: begin
                    bus.RegWrite = 1'b1;
                end
                JUMP: begin
                    bus.PCSrc   = 2'b10;
                    bus.PCWrite = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.State = state_q;

endmodule
